tx_result_scheduler: RTL and testbench

//  Queues ALU result bytes from the operand/opcode interface FSM and sequences them
//  one at a time into the UART transmitter over a start/done handshake. Sits

---
 rtl/tx_result_scheduler_pkg.sv | 23 ++
 rtl/tx_result_scheduler_fifo.sv | 59 +++++
 rtl/tx_result_scheduler.sv | 97 +++++++++
 tb/tb_tx_result_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_result_scheduler_pkg.sv
// Shared widths, one-hot scheduler states and FIFO status bundle for the
// ALU-result -> UART TX scheduler.
package tx_result_scheduler_pkg;

  localparam int NB_DATA_DEF        = 8;
  localparam int NB_STATE           = 4;
  localparam int TIMEOUT_CYCLES_DEF = 100000;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE  = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_START = 4'b0100,
    ST_WAIT  = 4'b1000
  } state_t;

  // FIFO status seen by the scheduler
  typedef struct packed {
    logic full;
    logic empty;
    logic drop;   // push rejected this cycle (full, no simultaneous pop)
  } fifo_stat_t;

endpackage

// File: rtl/tx_result_scheduler_fifo.sv
// Small synchronous FIFO holding result bytes waiting for the transmitter.
// Head is presented combinationally; a push into a full FIFO is accepted only
// when a pop happens on the same edge.
module result_fifo
  import tx_result_scheduler_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic [NB_DATA-1:0] i_push_data,
  input  logic               i_pop,
  output logic [NB_DATA-1:0] o_head,
  output fifo_stat_t         o_stat,
  output logic [NB_ADDR:0]   o_count
);

  localparam int               DEPTH   = 2**NB_ADDR;
  localparam logic [NB_ADDR:0] CNT_MAX = (NB_ADDR+1)'(DEPTH);

  logic [DEPTH-1:0][NB_DATA-1:0] mem;
  logic [NB_ADDR-1:0]            wr_ptr, rd_ptr;
  logic [NB_ADDR:0]              count;
  logic                          full, empty, do_push, do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_pop  = i_pop && !empty;
  assign do_push = i_push && (!full || do_pop);

  assign o_head  = mem[rd_ptr];
  assign o_count = count;
  assign o_stat  = '{full: full, empty: empty, drop: i_push && !do_push};

  // pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage; contents are don't-care until written, so no reset
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/tx_result_scheduler.sv
// Queues ALU result bytes and hands them one at a time to the UART TX over a
// start/done handshake. Flags dropped pushes (overflow) and a transmitter
// that never answers (timeout); both flags are sticky until reset.
module tx_result_scheduler
  import tx_result_scheduler_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_ADDR        = 2,
  parameter int NB_TIMEOUT     = 17,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_result_valid,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic [NB_ADDR:0]   o_fifo_count,
  output logic               o_overflow,
  output logic               o_timeout
);

  localparam logic [NB_TIMEOUT-1:0] TO_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [NB_TIMEOUT-1:0] timer;
  logic [NB_DATA-1:0]    head;
  fifo_stat_t            fstat;
  logic                  pop;

  // only IDLE pops, and only when something is queued
  assign pop    = (state == ST_IDLE) && !fstat.empty;
  assign o_busy = (state != ST_IDLE) || !fstat.empty;

  result_fifo #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (i_result_valid),
    .i_push_data (i_result),
    .i_pop       (pop),
    .o_head      (head),
    .o_stat      (fstat),
    .o_count     (o_fifo_count)
  );

  // scheduler FSM, watchdog timer and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_overflow <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      if (fstat.drop) o_overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            o_tx_data <= head;
            state     <= ST_LOAD;
          end
        end
        // one settle cycle so the UART sees stable data before start
        ST_LOAD: begin
          o_tx_start <= 1'b1;
          state      <= ST_START;
        end
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done) begin
            state <= ST_IDLE;
          end else if (timer == TO_LAST) begin
            o_timeout <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_result_scheduler.sv
// Directed bench for tx_result_scheduler: single byte, burst, overflow,
// pointer wrap, transmitter timeout and mid-transfer reset.
module tb_tx_result_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] result;
  logic       done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic [2:0] fcount;
  logic       ovf;
  logic       tout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tx_result_scheduler #(
    .NB_DATA        (8),
    .NB_ADDR        (2),
    .NB_TIMEOUT     (17),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_result_valid (valid),
    .i_result       (result),
    .i_tx_done      (done),
    .o_tx_start     (tx_start),
    .o_tx_data      (tx_data),
    .o_busy         (busy),
    .o_fifo_count   (fcount),
    .o_overflow     (ovf),
    .o_timeout      (tout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    valid  = 1'b1;
    result = b;
    tick();
    valid  = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // wait (bounded) for a start pulse, check its byte, then acknowledge it
  task automatic send_one(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, tx_start, 1'b1);
    chk({tag, "_data"}, tx_data, exp);
    tick();
    pulse_done();
  endtask

  initial begin
    int peak;
    int cnt;
    rst = 1'b1; valid = 1'b0; result = '0; done = 1'b0;
    tick(); tick();
    chk("rst_start", tx_start, 0);
    chk("rst_data",  tx_data,  0);
    chk("rst_busy",  busy,     0);
    chk("rst_count", fcount,   0);
    chk("rst_flags", {ovf, tout}, 0);
    rst = 1'b0;
    tick();

    // 1: single byte, start two edges after the push edge
    push(8'h5A);
    chk("t1_cnt1", fcount, 1);
    chk("t1_nostart", tx_start, 0);
    tick();
    chk("t1_cnt0", fcount, 0);
    chk("t1_busy_load", busy, 1);
    tick();
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'h5A);
    tick();
    chk("t1_start_1cyc", tx_start, 0);
    pulse_done();
    chk("t1_idle", busy, 0);

    // 2: burst of four on consecutive edges
    peak = 0;
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      result = 8'(i + 1);
      tick();
      if (int'(fcount) > peak) peak = int'(fcount);
      if (i == 2) chk("t2_first_start", tx_start, 1);
    end
    valid = 1'b0;
    chk("t2_peak", peak, 3);
    chk("t2_first_data", tx_data, 8'h01);
    pulse_done();
    send_one("t2_b2", 8'h02);
    send_one("t2_b3", 8'h03);
    send_one("t2_b4", 8'h04);
    chk("t2_ovf", ovf, 0);
    chk("t2_idle", busy, 0);

    // 3: overflow with the transmitter stalled
    valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      result = 8'(8'h31 + i);
      tick();
      if (i == 2) chk("t3_first_data", tx_data, 8'h31);
      if (i == 4) chk("t3_no_ovf_yet", ovf, 0);
    end
    valid = 1'b0;
    chk("t3_full", fcount, 4);
    chk("t3_ovf", ovf, 1);
    pulse_done();
    send_one("t3_b2", 8'h32);
    send_one("t3_b3", 8'h33);
    send_one("t3_b4", 8'h34);
    send_one("t3_b5", 8'h35);
    chk("t3_drained", fcount, 0);
    chk("t3_idle", busy, 0);
    chk("t3_ovf_sticky", ovf, 1);

    // 4: ten push/send rounds across pointer wrap
    for (int i = 0; i < 10; i++) begin
      push(8'(8'h10 + i));
      send_one($sformatf("t4_%0d", i), 8'(8'h10 + i));
    end
    chk("t4_idle", busy, 0);

    // 5: no done -> abort after 50 cycles in WAIT_DONE, next byte starts
    push(8'hA1);
    push(8'hA2);
    tick();
    chk("t5_start", tx_start, 1);
    chk("t5_data", tx_data, 8'hA1);
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (cnt == 50) chk("t5_tout_early", tout, 0);
      if (cnt == 51) chk("t5_tout_set", tout, 1);
    end while (!tx_start && cnt < 100);
    chk("t5_gap", cnt, 53);
    chk("t5_next_data", tx_data, 8'hA2);
    tick();
    pulse_done();
    chk("t5_idle", busy, 0);
    chk("t5_tout_sticky", tout, 1);

    // 6: reset in WAIT_DONE with two queued
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      result = 8'(8'hC1 + i);
      tick();
    end
    valid = 1'b0;
    tick();
    chk("t6_queued", fcount, 2);
    chk("t6_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_start", tx_start, 0);
    chk("t6_rst_data",  tx_data,  0);
    chk("t6_rst_busy",  busy,     0);
    chk("t6_rst_count", fcount,   0);
    chk("t6_rst_flags", {ovf, tout}, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_done();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start) cnt++;
    end
    chk("t6_no_start", cnt, 0);
    chk("t6_idle", busy, 0);
    chk("t6_count", fcount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
